keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles per column dwell (>=4).
REQ-002 SHALL have parameter DEBOUNCE_N, default 8: consecutive stable samples needed to accept a press or a release (>=1).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-high (asserted = 1, sampled on the clk rising edge).
REQ-005 SHALL have port row, input, 4: keypad rows, active-low, externally pulled up, asynchronous.
REQ-006 SHALL have port col, output, 4: column drive, active-low one-hot.
REQ-007 SHALL have port key_code, output, 4: accepted key index = row_idx*4 + col_idx.
REQ-008 SHALL have port key_valid, output, 1: key_code holds an unacknowledged key.
REQ-009 SHALL have port key_ack, input, 1: consumer acknowledge.
REQ-010 SHALL have port key_down, output, 1: a debounced key is currently held.
REQ-011 SHALL have port overrun, output, 1: sticky flag, a key was lost.

Function
REQ-012 SHALL pass row through a 2-flop synchronizer; all decisions use the synchronized value rs.
REQ-013 SHALL drive col = ~(4'b0001 << col_idx), col_idx a 2-bit counter.
REQ-014 SHALL generate a sample tick on the last cycle of every SCAN_DIV-cycle dwell, counting continuously in all states.
REQ-015 SHALL implement FSM states SCAN, PRESS_DB, HOLD, RELEASE_DB.
REQ-016 In SCAN, each tick with rs==4'hF SHALL increment col_idx, wrapping 3->0.
REQ-017 In SCAN, a tick with any rs bit low SHALL latch row_idx (lowest-index low bit wins), set the debounce count to 1, hold col_idx, and go to PRESS_DB.
REQ-018 In PRESS_DB, a tick with the latched row still low SHALL increment the count; on reaching DEBOUNCE_N the FSM SHALL go to HOLD and the key SHALL be accepted.
REQ-019 In PRESS_DB, a tick with the latched row high SHALL return the FSM to SCAN and advance col_idx.
REQ-020 When DEBOUNCE_N==1, the first detecting tick SHALL accept the key directly (SCAN->HOLD).
REQ-021 In HOLD, col_idx SHALL stay frozen and key_down SHALL be 1; a tick with the latched row high SHALL set the count to 1 and go to RELEASE_DB.
REQ-022 In RELEASE_DB, a tick with the row high SHALL increment the count; on reaching DEBOUNCE_N the FSM SHALL go to SCAN, advance col_idx, and clear key_down. A tick with the row low SHALL return the FSM to HOLD.
REQ-023 Key acceptance SHALL take effect in the cycle after the accepting tick: if key_valid==0, or key_ack==1 in the accepting tick's cycle, key_code SHALL load and key_valid SHALL be 1; otherwise key_code SHALL be kept and overrun SHALL set.
REQ-024 key_ack with key_valid==1 and no acceptance SHALL clear key_valid on the next cycle; key_ack with key_valid==0 SHALL be ignored.
REQ-025 Presses of other keys during HOLD/RELEASE_DB SHALL be ignored (no rollover).
REQ-026 overrun SHALL clear only on reset.

Reset
REQ-027 With rst_n==1 at a clk edge, the next-cycle state SHALL be: state SCAN, col_idx 0 (col=4'b1110), tick counter 0, debounce count 0, synchronizer 4'hF, key_code 0, key_valid 0, key_down 0, overrun 0.
REQ-028 Reset mid-debounce or mid-hold SHALL discard the pending key; no key_valid pulse results.

Verification (SCAN_DIV=4, DEBOUNCE_N=3)
REQ-029 Idle, rows 4'hF -> col cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid stays 0.
REQ-030 Key row1/col2 held 40 cycles -> key_code=6, key_valid=1 one cycle after the 3rd low tick, key_down=1 until 3 high ticks after release.
REQ-031 Row low for only 2 ticks (bounce) -> no key_valid; scan resumes at the next column.
REQ-032 Accept key 5 without ack, then press key 9 -> key_code stays 5, overrun=1; ack then clears key_valid next cycle.
REQ-033 key_ack in the same cycle as key 9 acceptance -> key_code=9, key_valid stays 1, overrun=0.
REQ-034 rst_n=1 during HOLD -> next cycle col=1110, key_valid=0, key_down=0, overrun=0.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one column low at a time, samples the
// synchronized rows once per column dwell, debounces press and release, and
// hands accepted keys to a consumer through a valid/ack pair with a sticky
// overrun flag for keys that arrive while the previous one is unacknowledged.
module keypad_scan #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE_N = 8
) (
    input  logic       clk,
    input  logic       rst_n,      // active-high synchronous reset despite the name
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_N + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N);

    localparam logic [1:0] S_SCAN       = 2'd0;
    localparam logic [1:0] S_PRESS_DB   = 2'd1;
    localparam logic [1:0] S_HOLD       = 2'd2;
    localparam logic [1:0] S_RELEASE_DB = 2'd3;

    logic [3:0]       r_sync1;
    logic [3:0]       r_rs;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_state;
    logic [1:0]       r_col_idx;
    logic [1:0]       r_row_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_overrun;

    logic             w_tick;
    logic             w_any_low;
    logic [1:0]       w_low_idx;
    logic             w_row_low;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [1:0]       w_state_nxt;
    logic [1:0]       w_col_nxt;
    logic [1:0]       w_row_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;
    logic [3:0]       w_acc_code;

    // Two-flop synchronizer for the asynchronous, pulled-up row inputs.
    // NOTE: non-blocking assignments so r_rs takes the old r_sync1, giving two real stages.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_sync1 <= 4'hF;
            r_rs    <= 4'hF;
        end else begin
            r_sync1 <= row;
            r_rs    <= r_sync1;
        end
    end

    // Free-running dwell counter; the tick marks the last cycle of each dwell.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_tick    = (r_div == DIV_LAST);
    assign w_any_low = ~&r_rs;
    assign w_row_low = ~r_rs[r_row_idx];
    assign w_cnt_inc = r_cnt + CNT_ONE;

    // Lowest-index active row wins when several rows read low.
    always_comb begin
        w_low_idx = 2'd0;
        if (!r_rs[0])      w_low_idx = 2'd0;
        else if (!r_rs[1]) w_low_idx = 2'd1;
        else if (!r_rs[2]) w_low_idx = 2'd2;
        else if (!r_rs[3]) w_low_idx = 2'd3;
    end

    // Scan/debounce FSM next-state logic; every decision happens on a tick.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_col_nxt   = r_col_idx;
        w_row_nxt   = r_row_idx;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_acc_code  = {r_row_idx, r_col_idx};
        case (r_state)
            S_SCAN: begin
                if (w_tick) begin
                    if (w_any_low) begin
                        w_row_nxt  = w_low_idx;
                        w_acc_code = {w_low_idx, r_col_idx};
                        w_cnt_nxt  = CNT_ONE;
                        if (DEBOUNCE_N == 1) begin
                            w_state_nxt = S_HOLD;
                            w_accept    = 1'b1;
                        end else begin
                            w_state_nxt = S_PRESS_DB;
                        end
                    end else begin
                        w_col_nxt = r_col_idx + 2'd1;
                    end
                end
            end
            S_PRESS_DB: begin
                if (w_tick) begin
                    if (w_row_low) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_LAST) begin
                            w_state_nxt = S_HOLD;
                            w_accept    = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_SCAN;
                        w_col_nxt   = r_col_idx + 2'd1;
                    end
                end
            end
            S_HOLD: begin
                if (w_tick && !w_row_low) begin
                    w_cnt_nxt = CNT_ONE;
                    // A single stable sample is already a complete release.
                    if (DEBOUNCE_N == 1) begin
                        w_state_nxt = S_SCAN;
                        w_col_nxt   = r_col_idx + 2'd1;
                    end else begin
                        w_state_nxt = S_RELEASE_DB;
                    end
                end
            end
            S_RELEASE_DB: begin
                if (w_tick) begin
                    if (!w_row_low) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_LAST) begin
                            w_state_nxt = S_SCAN;
                            w_col_nxt   = r_col_idx + 2'd1;
                        end
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            default: begin
                w_state_nxt = S_SCAN;
            end
        endcase
    end

    // FSM, column and debounce registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state   <= S_SCAN;
            r_col_idx <= 2'd0;
            r_row_idx <= 2'd0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_col_idx <= w_col_nxt;
            r_row_idx <= w_row_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Consumer handshake: an acceptance loads the key unless an unacked key is
    // still pending; an ack in the same cycle frees the slot for the new key.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_accept) begin
            if (!r_key_valid || key_ack) begin
                r_key_code  <= w_acc_code;
                r_key_valid <= 1'b1;
            end else begin
                r_overrun   <= 1'b1;
            end
        end else if (key_ack && r_key_valid) begin
            r_key_valid <= 1'b0;
        end
    end

    assign col       = ~(4'b0001 << r_col_idx);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_down  = (r_state == S_HOLD) || (r_state == S_RELEASE_DB);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a behavioural keypad drives the rows
// from the DUT's column drive, and a tick-level reference model predicts the
// outputs every cycle; directed scenarios are followed by randomized presses.
module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        key_down;
    logic        overrun;

    logic [15:0] key_mask;
    logic        force_en;
    logic [3:0]  force_val;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state (expressed in keypad terms, not DUT encoding)
    logic [3:0] m_sync1, m_rs;
    int         m_div, m_col, m_locked, m_run;
    bit         m_held;
    logic [3:0] m_code;
    logic       m_valid, m_ov;

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_N(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_down  (key_down),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Physical matrix: a row reads low when a pressed key sits on a driven column.
    function automatic logic [3:0] rows_for(input logic [3:0] c, input logic [15:0] m);
        logic [3:0] r;
        r = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (m[rr*4+cc] && !c[cc]) r[rr] = 1'b0;
        return r;
    endfunction

    function automatic logic [3:0] col_of(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    assign row = force_en ? force_val : rows_for(col, key_mask);

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync1 = 4'hF; m_rs = 4'hF;
        m_div = 0; m_col = 0; m_locked = -1; m_run = 0; m_held = 0;
        m_code = 4'd0; m_valid = 1'b0; m_ov = 1'b0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_update(input logic ack, input logic rst);
        logic [3:0] rin;
        bit tick, acc;
        int acc_row, lr;
        if (rst) begin
            model_reset();
            return;
        end
        rin  = force_en ? force_val : rows_for(col_of(m_col), key_mask);
        tick = (m_div == SD - 1);
        acc  = 0;
        acc_row = m_locked;
        if (tick) begin
            if (m_locked < 0) begin
                if (m_rs != 4'hF) begin
                    lr = 3;
                    for (int i = 3; i >= 0; i--) if (!m_rs[i]) lr = i;
                    m_locked = lr; acc_row = lr; m_run = 1;
                    if (DB == 1) begin m_held = 1; m_run = 0; acc = 1; end
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end else if (!m_held) begin
                if (!m_rs[m_locked]) begin
                    m_run++;
                    if (m_run == DB) begin m_held = 1; m_run = 0; acc = 1; end
                end else begin
                    m_locked = -1; m_col = (m_col + 1) % 4;
                end
            end else begin
                if (m_rs[m_locked]) begin
                    m_run++;
                    if (m_run == DB) begin
                        m_held = 0; m_locked = -1; m_run = 0; m_col = (m_col + 1) % 4;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
        if (acc) begin
            if (!m_valid || ack) begin
                m_code  = 4'(acc_row * 4 + m_col);
                m_valid = 1'b1;
            end else begin
                m_ov = 1'b1;
            end
        end else if (ack && m_valid) begin
            m_valid = 1'b0;
        end
        m_rs    = m_sync1;
        m_sync1 = rin;
        m_div   = (m_div + 1) % SD;
    endtask

    // True when the coming edge is the one on which the model accepts a key.
    function automatic bit accept_pending();
        return (m_div == SD - 1) && (m_locked >= 0) && !m_held &&
               (m_run == DB - 1) && !m_rs[m_locked];
    endfunction

    task automatic step(input logic ack, input logic rst);
        key_ack = ack;
        rst_n   = rst;
        model_update(ack, rst);
        @(negedge clk);
        check("col",       col,       col_of(m_col));
        check("key_code",  key_code,  m_code);
        check("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
        check("key_down",  {3'b0, key_down},  {3'b0, m_held});
        check("overrun",   {3'b0, overrun},   {3'b0, m_ov});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    initial begin
        bit hit;
        key_mask  = 16'h0;
        force_en  = 1'b0;
        force_val = 4'hF;
        key_ack   = 1'b0;
        rst_n     = 1'b1;
        model_reset();

        // Reset state
        do_reset();
        check("rst_col",   col,        4'b1110);
        check("rst_code",  key_code,   4'd0);
        check("rst_valid", {3'b0, key_valid}, 4'd0);

        // Idle scan: columns walk one position every SD cycles
        for (int k = 1; k <= 4; k++) begin
            run(SD);
            check("idle_col", col, col_of(k % 4));
        end
        run(8);
        check("idle_valid", {3'b0, key_valid}, 4'd0);

        // Key at row1/col2 held, then released
        key_mask = 16'h0040;
        run(40);
        check("k6_code",  key_code, 4'd6);
        check("k6_valid", {3'b0, key_valid}, 4'd1);
        check("k6_down",  {3'b0, key_down},  4'd1);
        key_mask = 16'h0;
        run(30);
        check("k6_up", {3'b0, key_down}, 4'd0);
        step(1'b1, 1'b0);
        check("k6_ack", {3'b0, key_valid}, 4'd0);

        // Bounce: rows low for two ticks only
        do_reset();
        run(3);
        force_en  = 1'b1;
        force_val = 4'b1101;
        run(2 * SD);
        force_en  = 1'b0;
        run(20);
        check("bounce_valid", {3'b0, key_valid}, 4'd0);
        check("bounce_down",  {3'b0, key_down},  4'd0);

        // Overrun: key 5 not acked, then key 9
        do_reset();
        key_mask = 16'h0020; run(40); key_mask = 16'h0; run(40);
        key_mask = 16'h0200; run(40); key_mask = 16'h0; run(40);
        check("ovr_code",  key_code, 4'd5);
        check("ovr_flag",  {3'b0, overrun}, 4'd1);
        step(1'b1, 1'b0);
        check("ovr_ack",   {3'b0, key_valid}, 4'd0);

        // Ack in the very cycle key 9 is accepted
        do_reset();
        key_mask = 16'h0020; run(40); key_mask = 16'h0; run(40);
        key_mask = 16'h0200;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            hit = accept_pending();
            step(hit ? 1'b1 : 1'b0, 1'b0);
        end
        check("same_hit",   {3'b0, hit}, 4'd1);
        check("same_code",  key_code, 4'd9);
        check("same_valid", {3'b0, key_valid}, 4'd1);
        check("same_ovr",   {3'b0, overrun}, 4'd0);
        key_mask = 16'h0; run(40);

        // Reset while a key is held
        key_mask = 16'h0001;
        for (int i = 0; i < 200 && !m_held; i++) run(1);
        run(3);
        step(1'b0, 1'b1);
        check("hr_col",   col, 4'b1110);
        check("hr_valid", {3'b0, key_valid}, 4'd0);
        check("hr_down",  {3'b0, key_down},  4'd0);
        check("hr_ovr",   {3'b0, overrun},   4'd0);
        key_mask = 16'h0;
        run(20);

        // Randomized presses, releases and acknowledges
        for (int seg = 0; seg < 40; seg++) begin
            int sel, dur;
            sel = int'($urandom_range(0, 9));
            if (sel < 5)      key_mask = 16'h0;
            else if (sel < 9) key_mask = 16'h1 << $urandom_range(0, 15);
            else              key_mask = (16'h1 << $urandom_range(0, 15)) |
                                         (16'h1 << $urandom_range(0, 15));
            dur = int'($urandom_range(10, 90));
            for (int i = 0; i < dur; i++)
                step(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
